// File: rtl/fpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_ctrl                                                                  |
// | Sequences one FPU operation: operand latch, unit start strobe, fixed      |
// | latency wait, result capture behind a valid/ready output handshake.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fpu_ctrl #(
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [1:0]  op_code,
   output logic        add_start,
   output logic        mul_start,
   output logic        div_start,
   input  logic [31:0] mux_result,
   input  logic        mux_error,
   input  logic        mux_overflow,
   input  logic        mux_underflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_error,
   output logic        out_overflow,
   output logic        out_underflow,
   output logic        sticky_err,
   output logic        sticky_ovf,
   output logic        sticky_udf,
   input  logic        clr_sticky,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] C_ADD_CNT = 4'(ADD_LAT - 1);
   localparam logic [3:0] C_MUL_CNT = 4'(MUL_LAT - 1);
   localparam logic [3:0] C_DIV_CNT = 4'(DIV_LAT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_accept;
   logic        w_capture;

   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [1:0]  r_op_code;
   logic [31:0] r_out_result;
   logic        r_out_error;
   logic        r_out_overflow;
   logic        r_out_underflow;
   logic        r_sticky_err;
   logic        r_sticky_ovf;
   logic        r_sticky_udf;

   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd0);

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_next = S_START;
         end
         S_START: begin
            unique case (r_op_code)
               2'b10:   w_cnt_next = C_MUL_CNT;
               2'b11:   w_cnt_next = C_DIV_CNT;
               default: w_cnt_next = C_ADD_CNT;
            endcase
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_next = S_DONE;
            else               w_cnt_next = r_cnt - 4'd1;
         end
         S_DONE: begin
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= 4'd0;
         r_op_a          <= 32'd0;
         r_op_b          <= 32'd0;
         r_op_code       <= 2'd0;
         r_out_result    <= 32'd0;
         r_out_error     <= 1'b0;
         r_out_overflow  <= 1'b0;
         r_out_underflow <= 1'b0;
         r_sticky_err    <= 1'b0;
         r_sticky_ovf    <= 1'b0;
         r_sticky_udf    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_op_a    <= in_a;
            r_op_b    <= in_b;
            r_op_code <= in_op;
         end
         if (w_capture) begin
            r_out_result    <= mux_result;
            r_out_error     <= mux_error;
            r_out_overflow  <= mux_overflow;
            r_out_underflow <= mux_underflow;
         end
         // A capture on the same edge as a clear must leave the new flags set.
         r_sticky_err <= (r_sticky_err & ~clr_sticky) | (w_capture & mux_error);
         r_sticky_ovf <= (r_sticky_ovf & ~clr_sticky) | (w_capture & mux_overflow);
         r_sticky_udf <= (r_sticky_udf & ~clr_sticky) | (w_capture & mux_underflow);
      end
   end

   // in_ready is held low while rst is asserted so every output reads 0 in reset.
   assign in_ready      = (r_state == S_IDLE) && !rst;
   assign busy          = (r_state != S_IDLE);
   assign out_valid     = (r_state == S_DONE);
   assign add_start     = (r_state == S_START) && !r_op_code[1];
   assign mul_start     = (r_state == S_START) && (r_op_code == 2'b10);
   assign div_start     = (r_state == S_START) && (r_op_code == 2'b11);
   assign op_a          = r_op_a;
   assign op_b          = r_op_b;
   assign op_code       = r_op_code;
   assign out_result    = r_out_result;
   assign out_error     = r_out_error;
   assign out_overflow  = r_out_overflow;
   assign out_underflow = r_out_underflow;
   assign sticky_err    = r_sticky_err;
   assign sticky_ovf    = r_sticky_ovf;
   assign sticky_udf    = r_sticky_udf;

endmodule
`default_nettype wire
